wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 60 ++++++
 tb/tb_wb_regfile.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back select, NREG x DW register file with two combinational read ports,
// plus a retired-write counter and last-write record. Optional macro: WB_BYPASS_EN.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memToReg,
  input  logic [DW-1:0] dataMem,
  input  logic          regWrt,
  input  logic [4:0]    rd,
  input  logic [DW-1:0] adder,
  input  logic          svpc,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  output logic [DW-1:0] rsData,
  output logic [DW-1:0] rtData,
  output logic [DW-1:0] wbData,
  output logic [31:0]   wrCount,
  output logic [4:0]    lastRd,
  output logic [DW-1:0] lastData
);

  logic [DW-1:0] regs [NREG];

  // svpc overrides memToReg, so adder wins whenever either selects it
  always_comb begin
    wbData = (svpc || !memToReg) ? adder : dataMem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wrCount  <= '0;
      lastRd   <= '0;
      lastData <= '0;
    end else if (regWrt) begin
      if (32'(rd) < NREG) begin
        regs[rd] <= wbData;
      end
      wrCount  <= wrCount + 32'd1;
      lastRd   <= rd;
      lastData <= wbData;
    end
  end

  always_comb begin
    rsData = (32'(rs) < NREG) ? regs[rs] : '0;
    rtData = (32'(rt) < NREG) ? regs[rt] : '0;
`ifdef WB_BYPASS_EN
    // Forward the in-flight write so decode sees it in the same cycle
    if (regWrt && (rd == rs)) rsData = wbData;
    if (regWrt && (rd == rt)) rtData = wbData;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        memToReg;
  logic [31:0] dataMem;
  logic        regWrt;
  logic [4:0]  rd;
  logic [31:0] adder;
  logic        svpc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] wbData;
  logic [31:0] wrCount;
  logic [4:0]  lastRd;
  logic [31:0] lastData;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [32];
  logic [31:0] mcount;
  logic [4:0]  mlast_rd;
  logic [31:0] mlast_data;

  wb_regfile #(.NREG(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .memToReg(memToReg), .dataMem(dataMem),
    .regWrt(regWrt), .rd(rd), .adder(adder), .svpc(svpc),
    .rs(rs), .rt(rt), .rsData(rsData), .rtData(rtData), .wbData(wbData),
    .wrCount(wrCount), .lastRd(lastRd), .lastData(lastData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    if (svpc) return adder;
    if (memToReg) return dataMem;
    return adder;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
`ifdef WB_BYPASS_EN
    if (regWrt && rd == a) return exp_wb();
`endif
    return mdl[a];
  endfunction

  // One cycle: drive at negedge, check combinational and state outputs, clock, update model.
  task automatic cyc(input string tag, input logic r, input logic we, input logic m2r,
                     input logic sp, input logic [4:0] d, input logic [31:0] add,
                     input logic [31:0] dm, input logic [4:0] a, input logic [4:0] b);
    rst = r; regWrt = we; memToReg = m2r; svpc = sp; rd = d;
    adder = add; dataMem = dm; rs = a; rt = b;
    #1;
    chk({tag, ".wbData"},   wbData,        exp_wb());
    chk({tag, ".rsData"},   rsData,        exp_read(a));
    chk({tag, ".rtData"},   rtData,        exp_read(b));
    chk({tag, ".wrCount"},  wrCount,       mcount);
    chk({tag, ".lastRd"},   32'(lastRd),   32'(mlast_rd));
    chk({tag, ".lastData"}, lastData,      mlast_data);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mcount = '0; mlast_rd = '0; mlast_data = '0;
    end else if (we) begin
      mdl[d] = exp_wb();
      mcount = mcount + 1;
      mlast_rd = d;
      mlast_data = exp_wb();
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 'x;
    mcount = 'x; mlast_rd = 'x; mlast_data = 'x;
    rst = 1'b1; regWrt = 1'b0; memToReg = 1'b0; svpc = 1'b0;
    rd = '0; adder = '0; dataMem = '0; rs = '0; rt = '0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcount = '0; mlast_rd = '0; mlast_data = '0;
    @(negedge clk);

    cyc("rst_state",  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
    cyc("wr_r5",      0, 1, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd4);
    cyc("rst_vs_wr",  1, 1, 0, 0, 5'd4, 32'h12345678, 32'h0, 5'd5, 5'd4);
    cyc("post_rst",   0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd4);

    cyc("sel_mem",    0, 1, 1, 0, 5'd3, 32'h22, 32'h11, 5'd3, 5'd0);
    cyc("sel_svpc",   0, 1, 1, 1, 5'd3, 32'h22, 32'h11, 5'd3, 5'd0);
    cyc("sel_alu",    0, 1, 0, 0, 5'd3, 32'h22, 32'h11, 5'd3, 5'd0);
    cyc("chk_r3",     0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);

    cyc("no_write",   0, 0, 0, 0, 5'd7, 32'h55, 32'h0, 5'd7, 5'd3);
    cyc("chk_r7",     0, 0, 0, 0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd3);

    cyc("hazard",     0, 1, 0, 0, 5'd9, 32'hA5A5, 32'h0, 5'd9, 5'd9);
    cyc("hazard_nxt", 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);

    cyc("wr_r0",      0, 1, 0, 0, 5'd0, 32'h1, 32'h0, 5'd0, 5'd31);
    cyc("wr_r31",     0, 1, 1, 0, 5'd31, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd31);
    cyc("dual_port",  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd31);
    cyc("same_addr",  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd31);

    for (int n = 0; n < 300; n++) begin
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 5) == 0), 5'($urandom),
          $urandom, $urandom, 5'($urandom), 5'($urandom));
    end

    force dut.wrCount = 32'hFFFFFFFF;
    #1;
    release dut.wrCount;
    mcount = 32'hFFFFFFFF;
    cyc("wrap_pre",   0, 1, 0, 0, 5'd12, 32'hCAFE, 32'h0, 5'd12, 5'd0);
    cyc("wrap_post",  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
